// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter that shares it:
// function codes, the highest legal code and the shifter encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_func_e;

    localparam logic [3:0] ALU_FUNC_MAX = 4'd9;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'd0,
        SHIFT_RL = 2'd1,
        SHIFT_RA = 2'd2
    } shift_type_e;

    // Codes above ALU_FUNC_MAX still execute (as a logical right shift)
    // but are flagged to the requester.
    function automatic logic func_illegal(input logic [3:0] func);
        return func > ALU_FUNC_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU. Unknown function codes fall through to the
// logical right shift.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  func,
    output logic [31:0] result
);
    import alu_pkg::*;

    shift_type_e shift_type;
    logic [31:0] shift_res;

    // Shared shifter: pick the shift flavour from the function code.
    always_comb begin
        shift_type = SHIFT_RL;
        case (func)
            ALU_SLL: shift_type = SHIFT_LL;
            ALU_SRA: shift_type = SHIFT_RA;
            default: shift_type = SHIFT_RL;
        endcase
        shift_res = a >> b[4:0];
        case (shift_type)
            SHIFT_LL: shift_res = a << b[4:0];
            SHIFT_RA: shift_res = $signed(a) >>> b[4:0];
            default:  shift_res = a >> b[4:0];
        endcase
    end

    // Result select.
    always_comb begin
        result = shift_res;
        case (func)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = shift_res;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The requester after ptr has the
// highest priority; priority rises with the index and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);
    int   pos;
    logic found;

    // Walk positions ptr+1, ptr+2, ... (mod NUM_REQ) and grant the first active one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enable && !found && req[i] && (pos == i)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin issue into an
// operand register (S1), ALU, then a response register (S2).
//
// Handshake: a transfer on any channel happens on a rising edge where
// valid && ready are both high. req_ready is computed from req_valid and
// pipeline occupancy, so requesters must not derive req_valid from
// req_ready. Once resp_valid rises it stays high, with resp_data/resp_id/
// resp_err stable, until a cycle with resp_ready high.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_func,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_err
);
    import alu_pkg::*;

    // S1: issue register
    logic            s1_v_q,    s1_v_d;
    logic [31:0]     s1_a_q,    s1_a_d;
    logic [31:0]     s1_b_q,    s1_b_d;
    logic [3:0]      s1_func_q, s1_func_d;
    logic [ID_W-1:0] s1_id_q,   s1_id_d;
    // Round-robin pointer: index of the most recent grant
    logic [ID_W-1:0] ptr_q,     ptr_d;
    // S2: response register
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q,  resp_data_d;
    logic [ID_W-1:0] resp_id_q,    resp_id_d;
    logic            resp_err_q,   resp_err_d;

    logic               s2_free, s1_adv, s1_free, arb_en, accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [31:0]        sel_a, sel_b, alu_result;
    logic [3:0]         sel_func;

    assign s2_free = !resp_valid_q || resp_ready;
    assign s1_adv  = s1_v_q && s2_free;
    assign s1_free = !s1_v_q || s1_adv;
    // No grants while reset is held, so nothing is accepted then discarded.
    assign arb_en  = s1_free && rst_n;
    assign accept  = |grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    // Steer the granted requester's operands towards S1.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_func = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[32*i +: 32];
                sel_b    = req_b[32*i +: 32];
                sel_func = req_func[4*i +: 4];
            end
        end
    end

    alu u_alu (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .func   (s1_func_q),
        .result (alu_result)
    );

    // Next state for both stages; a drain and a refill in the same cycle keep the valid high.
    always_comb begin
        s1_v_d       = s1_v_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_func_d    = s1_func_q;
        s1_id_d      = s1_id_q;
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;

        if (s1_adv) begin
            s1_v_d = 1'b0;
        end
        if (accept) begin
            s1_v_d    = 1'b1;
            s1_a_d    = sel_a;
            s1_b_d    = sel_b;
            s1_func_d = sel_func;
            s1_id_d   = grant_idx;
            ptr_d     = grant_idx;
        end

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
        if (s1_adv) begin
            resp_valid_d = 1'b1;
            resp_data_d  = alu_result;
            resp_id_d    = s1_id_q;
            resp_err_d   = func_illegal(s1_func_q);
        end
    end

    // Pipeline registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_func_q    <= '0;
            s1_id_q      <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_func_q    <= s1_func_d;
            s1_id_q      <= s1_id_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single-cycle `alu` between up to four requesters, such as the execute stage, the address generator and a debug port. It has a per-requester valid/ready request channel and one common response channel tagged with the requester index. Operands are registered before the ALU and the result is registered after it, giving a two-stage pipeline with full backpressure. Throughput is one operation per cycle.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default 2: width of `resp_id`; must satisfy 2^ID_W >= NUM_REQ.

Ports (clock and reset first):
- `clk` input 1: single clock. **One clock; reset is synchronous and active-low.**
- `rst_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `req_valid` input NUM_REQ: bit i means requester i presents an operation.
- `req_ready` output NUM_REQ: bit i means requester i is granted this cycle; the transfer happens when `req_valid[i] && req_ready[i]`.
- `req_a` input NUM_REQ*32: operand A; slice i is `[32*i+31:32*i]`.
- `req_b` input NUM_REQ*32: operand B.
- `req_func` input NUM_REQ*4: ALU function code for each requester.
- `resp_valid` output 1: the response is valid.
- `resp_ready` input 1: the consumer accepts the response.
- `resp_data` output 32: ALU result.
- `resp_id` output ID_W: index of the requester that issued the operation.
- `resp_err` output 1: set when the function code was illegal (greater than 9).

## Operation
Stages:
- **S1 (issue register):** holds `s1_v`, a, b, func and id.
- **S2 (response register):** holds `resp_valid`, `resp_data`, `resp_id` and `resp_err`.

Advance conditions:
- `s2_free = !resp_valid || resp_ready`.
- `s1_adv = s1_v && s2_free`.
- `s1_free = !s1_v || s1_adv`.

Arbitration:
- Arbitration is combinational. Priority starts at `ptr+1` modulo NUM_REQ and rises from there.
- Exactly one `req_ready` bit goes high: the bit for the highest-priority requester with `req_valid` set, and only when `s1_free` is high. All other bits are 0.
- `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On an accept, S1 loads the operands and the granted index, and `ptr` takes the granted index. `ptr` does not change when no accept occurs.

ALU and response:
- The `alu` is driven from the S1 registers.
- On `s1_adv`, S2 captures the ALU output, the id, and `err = (func > 4'd9)`.
- For illegal function codes, `resp_data` carries whatever the ALU produces (its default is a logical right shift) and `resp_err` is 1.

Simultaneous events:
- If S2 drains and S1 advances in the same cycle, `resp_valid` stays 1 with the new data.
- If S1 advances and a new accept happens in the same cycle, `s1_v` stays 1.

Stability:
- While `resp_valid && !resp_ready`, `resp_data`, `resp_id` and `resp_err` hold stable.
- Once `resp_valid` is asserted, it does not drop until `resp_ready` is seen.

Reset:
- `rst_n` low at an edge clears `s1_v` and `resp_valid`, zeroes `resp_data`, `resp_id` and `resp_err`, and sets `ptr` to NUM_REQ-1, so requester 0 wins first.
- While `rst_n` is low, `req_ready` is forced to 0.
- In-flight operations are discarded; no response is produced for them.

## Timing
- Latency: an accept at edge N puts the result into S2 at edge N+1, so `resp_valid` is high in the cycle after edge N+1, provided S2 was free.
- Back-to-back accepts run with no bubbles while `resp_ready` is held at 1.
- Backpressure:
  - With S2 full and `resp_ready` = 0, S1 holds its contents.
  - If S1 is also full, all `req_ready` bits are 0 within the same cycle.
  - Maximum occupancy is 2 operations.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 accepts between its own grants.
- Reset values: `req_ready` = 0, `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_err` = 0.

## Structure
Shared package `alu_pkg`:
- The 4-bit function codes: Add 0, Sub 1, And 2, Or 3, Xor 4, Slt 5, Sltu 6, Sll 7, Srl 8, Sra 9.
- `ALU_FUNC_MAX = 9`.
- The shift-type encodings used by the shifter.

Sub-modules:
- Natural sub-module `rr_arbiter`: takes `req`, `ptr` and `enable`, and produces a one-hot `grant` and an encoded `grant_idx`. It is purely combinational.
- `alu` is instantiated once, unchanged.

## Test plan
- **Single request, subtract:** req0 issues a=5, b=3, func=1 with `resp_ready` = 1. Expect `resp_data` = 2, `resp_id` = 0, `resp_err` = 0, with `resp_valid` high in the second cycle after the accept.
- **Round-robin contention:** req0 and req1 both hold valid for 4 accepts, with `resp_ready` = 1. Expect grants in the order 0, 1, 0, 1, one per cycle, and `resp_id` following the sequence 0, 1, 0, 1.
- **Backpressure:** hold `resp_ready` = 0 for 3 cycles with both stages full. Expect all `req_ready` bits = 0 and `resp_data` stable. After releasing `resp_ready`, expect both results delivered in order on consecutive cycles.
- **Signed versus unsigned and arithmetic shift:**
  - a=32'hFFFFFFFF, b=1, Slt gives 1; the same operands with Sltu give 0.
  - a=32'h80000000, b=4, Sra gives 32'hF8000000.
- **Illegal function code:** func=4'hC with a=32'h10, b=1 gives `resp_err` = 1 and `resp_data` = 32'h8.
- **Reset mid-operation:** drive `rst_n` low for one edge with S1 and S2 full. Expect `resp_valid` = 0 on the next cycle and no stale responses. With both requesters then valid, the first grant goes to req0.
